// File: rtl/countdown_sequencer_pkg.sv
// Shared types and constants for the countdown sequencer and its prescaler.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF = 1;
  localparam int PRESCALE_W   = 8;

endpackage

// File: rtl/countdown_sequencer_tick_gen.sv
// Prescaler: pulses tick on every TICK_DIV-th enabled clock; frozen while en is low.
module tick_gen
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Down-counting sequencer with optional auto-reload, pause/hold and abort.
//   state   | meaning
//   ST_IDLE | waiting for a command, count held at 0
//   ST_RUN  | decrementing on each prescaler tick
//   ST_HOLD | paused, count and prescaler frozen
//   ST_DONE | terminal count reached, count held at 0, new command allowed
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_load,
  input  logic             cmd_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             pre_clr;
  logic             tick;

  assign cmd_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    pre_clr  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
      pre_clr = 1'b1;
    end else if (accept) begin
      count_d  = cmd_load;
      reload_d = cmd_load;
      mode_d   = cmd_reload;
      pre_clr  = 1'b1;
      if (cmd_load == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
            end else if (mode_q) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
          // A coincident tick is applied first; terminal count wins over pause.
          if (pause && (state_d == ST_RUN)) state_d = ST_HOLD;
        end
        ST_HOLD: if (!pause) state_d = ST_RUN;
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Two sequencers (TICK_DIV 1 and 3) share stimulus; each is compared to a cycle-level behavioural model.
module tb_countdown_sequencer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [W-1:0] cmd_load = '0;
  logic cmd_reload = 1'b0;
  logic pause = 1'b0;
  logic abort = 1'b0;

  logic [1:0]        ready_o, busy_o, done_o;
  logic [1:0][W-1:0] count_o;

  always #5 clk = ~clk;

  countdown_sequencer #(.WIDTH(W), .TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
    .cmd_load(cmd_load), .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
    .count(count_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  countdown_sequencer #(.WIDTH(W), .TICK_DIV(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
    .cmd_load(cmd_load), .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
    .count(count_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: "active" means a count is in progress, "held" means paused,
  // run_clks counts clocks spent actually running since the last accept.
  int td[2] = '{1, 3};
  bit m_active[2], m_held[2], m_done[2], m_mode[2];
  int m_count[2], m_reload[2], m_run_clks[2];
  bit synced = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit v, input int ld, input bit rl,
                            input bit p, input bit a, input bit r);
    if (r) begin
      m_active[i] = 0; m_held[i] = 0; m_done[i] = 0; m_mode[i] = 0;
      m_count[i] = 0; m_reload[i] = 0; m_run_clks[i] = 0;
    end else if (a) begin
      m_active[i] = 0; m_held[i] = 0; m_done[i] = 0;
      m_count[i] = 0; m_run_clks[i] = 0;
    end else if (v && !m_active[i]) begin
      m_count[i] = ld; m_reload[i] = ld; m_mode[i] = rl; m_run_clks[i] = 0;
      m_held[i] = 0;
      m_active[i] = (ld != 0);
      m_done[i] = (ld == 0);
    end else if (m_active[i] && !m_held[i]) begin
      m_done[i] = 0;
      m_run_clks[i]++;
      if (m_run_clks[i] % td[i] == 0) begin
        if (m_count[i] > 1) m_count[i]--;
        else begin
          m_done[i] = 1;
          if (m_mode[i]) m_count[i] = m_reload[i];
          else begin m_count[i] = 0; m_active[i] = 0; end
        end
      end
      if (p && m_active[i]) m_held[i] = 1;
    end else begin
      m_done[i] = 0;
      if (m_active[i] && !p) m_held[i] = 0;
    end
  endtask

  // One clock: check registered outputs, drive inputs, check cmd_ready, advance model.
  task automatic cycle(input bit v, input int ld, input bit rl, input bit p,
                       input bit a, input bit r);
    if (synced) begin
      for (int i = 0; i < 2; i++) begin
        check_val($sformatf("count%0d", i), int'(count_o[i]), m_count[i]);
        check_val($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_active[i]));
        check_val($sformatf("done%0d", i), int'(done_o[i]), int'(m_done[i]));
      end
    end
    cmd_valid = v; cmd_load = W'(ld); cmd_reload = rl; pause = p; abort = a; rst = r;
    #1;
    if (synced) begin
      for (int i = 0; i < 2; i++)
        check_val($sformatf("cmd_ready%0d", i), int'(ready_o[i]), int'(!m_active[i] && !a));
    end
    for (int i = 0; i < 2; i++) model_step(i, v, ld, rl, p, a, r);
    if (r) synced = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 7, 0, 0, 0, 1);
    idle(1);
    // countdown from 5
    cycle(1, 5, 0, 0, 0, 0);
    idle(18);
    // zero load goes straight to terminal
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    // auto-reload from 3
    cycle(1, 3, 1, 0, 0, 0);
    idle(12);
    cycle(0, 0, 0, 0, 1, 0);
    // pause in the middle of a count from 8
    cycle(1, 8, 0, 0, 0, 0);
    idle(2);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0, 0);
    idle(10);
    cycle(0, 0, 0, 0, 1, 0);
    // abort together with a command
    cycle(1, 9, 0, 0, 0, 0);
    idle(2);
    cycle(1, 9, 0, 0, 1, 0);
    idle(2);
    // reset mid-count
    cycle(1, 9, 0, 0, 0, 0);
    idle(4);
    cycle(0, 0, 0, 0, 0, 1);
    idle(2);
    for (int k = 0; k < 3000; k++) begin
      automatic bit v  = ($urandom_range(0, 3) == 0);
      automatic int ld = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                                     : int'($urandom_range(0, 15));
      automatic bit rl = ($urandom_range(0, 2) == 0);
      automatic bit p  = ($urandom_range(0, 5) == 0);
      automatic bit a  = ($urandom_range(0, 40) == 0);
      automatic bit r  = ($urandom_range(0, 150) == 0);
      cycle(v, ld, rl, p, a, r);
    end
    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter TICK_DIV, default 1: clocks per decrement, range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  start command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 SHALL have port cmd_load  input  WIDTH  start value, sampled on accept.
REQ-008 SHALL have port cmd_reload  input  1  auto-reload mode, sampled on accept.
REQ-009 SHALL have port pause  input  1  level; freezes counting while high.
REQ-010 SHALL have port abort  input  1  stops the sequence; takes priority over every input except rst.
REQ-011 SHALL have port count  output  WIDTH  current count value, registered.
REQ-012 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-013 SHALL have port done  output  1  one-cycle pulse at terminal count, registered.

Function
REQ-014 SHALL implement states IDLE, RUN, HOLD, DONE.
REQ-015 cmd_ready SHALL equal (state==IDLE or state==DONE) and not abort.
REQ-016 On accept, the block SHALL latch count<=cmd_load, reload_val<=cmd_load and mode<=cmd_reload, and SHALL clear the prescaler.
REQ-017 On accept with cmd_load!=0, next state SHALL be RUN; with cmd_load==0, next state SHALL be DONE and done SHALL be 1 in the following cycle.
REQ-018 The prescaler SHALL emit tick on every TICK_DIV-th clk spent in RUN, so the first decrement occurs TICK_DIV cycles after accept.
REQ-019 In RUN, on tick with count>1, the block SHALL set count<=count-1.
REQ-020 In RUN, on tick with count==1 and mode=0, the block SHALL set count<=0, state<=DONE and done<=1 for one cycle.
REQ-021 In RUN, on tick with count==1 and mode=1, the block SHALL set count<=reload_val, stay in RUN and set done<=1 for one cycle; count never shows 0 in reload mode.
REQ-022 count SHALL never wrap below 0; no decrement SHALL occur outside RUN.
REQ-023 pause=1 in RUN SHALL move the block to HOLD next cycle, with count and prescaler frozen; pause=0 in HOLD SHALL return it to RUN; pause SHALL be ignored in IDLE and DONE.
REQ-024 pause and a tick in the same RUN cycle SHALL apply the tick, then enter HOLD.
REQ-025 abort=1 in any state SHALL give state<=IDLE, count<=0, prescaler cleared and no done pulse; abort together with cmd_valid SHALL not accept.
REQ-026 DONE SHALL hold count=0 until a new accept or an abort; an accept in DONE SHALL enter RUN, or DONE again if cmd_load==0.

Reset
REQ-027 rst=1 at a clk edge SHALL force state=IDLE, count=0, done=0, busy=0, reload_val=0, mode=0 and prescaler=0, overriding all other inputs, including mid-count.
REQ-028 After rst deasserts, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-029 The state encoding and the TICK_DIV default SHALL live in shared package countdown_pkg.
REQ-030 The prescaler SHALL be sub-module tick_gen (ports: clk, rst, clr, en, tick).
REQ-031 All outputs SHALL be registered except cmd_ready.

Verification
REQ-032 TICK_DIV=1, load 5, reload=0 -> count 5,4,3,2,1,0 on consecutive cycles; done high exactly one cycle, coincident with count=0; busy low from that cycle.
REQ-033 TICK_DIV=3, load 2 -> decrements 3 and 6 cycles after accept; done at cycle 6; cmd_ready high again in DONE.
REQ-034 TICK_DIV=1, load 3, reload=1, run 10 cycles -> count 3,2,1,3,2,1,3,...; done pulses every 3 cycles; count never 0.
REQ-035 TICK_DIV=1, load 8, pause high for 4 cycles at count=5 -> count holds 5 (after any coincident tick) and busy stays 1; resumes 4,3,...
REQ-036 Load 9, abort with cmd_valid at count=6 -> count=0, IDLE, no done, command not accepted; rst mid-count at 4 -> all outputs reset next edge.
REQ-037 Load 0 -> DONE, done=1 one cycle after accept, count=0, busy never 1.
